// File: rtl/mmm_redc_seq_if.sv
// Handshake bundle for the Montgomery REDC sequencer.
//   master side (upstream/downstream driver): i_valid, i_t, i_n, i_nprime, i_ready
//   slave side  (mmm_redc_seq):               o_ready, o_valid, o_res
//   i_t      : product T from the multiplier (only the low 2*IDW bits are used)
//   i_n      : odd modulus N
//   i_nprime : -N^-1 mod 2^WW
//   o_res    : T * 2^-IDW mod N
interface mmm_redc_seq_if #(
    parameter int IDW = 256,
    parameter int TDW = 522,
    parameter int WW  = 64
);
    logic           i_valid;
    logic           o_ready;
    logic [TDW-1:0] i_t;
    logic [IDW-1:0] i_n;
    logic [WW-1:0]  i_nprime;
    logic           o_valid;
    logic           i_ready;
    logic [IDW-1:0] o_res;

    modport master (
        output i_valid, i_t, i_n, i_nprime, i_ready,
        input  o_ready, o_valid, o_res
    );

    modport slave (
        input  i_valid, i_t, i_n, i_nprime, i_ready,
        output o_ready, o_valid, o_res
    );
endinterface

// File: rtl/mmm_redc_seq.sv
// Word-serial Montgomery reduction: o_res = T * 2^-IDW mod N.
// One request in flight; WW-bit digits, NW = IDW/WW iterations of
// (compute m, accumulate m*N and shift), then one conditional subtract.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : mmm_redc_seq_if slave (valid/ready request in, valid/ready result out)
//
// state | meaning
// IDLE  | o_ready=1, waiting for a request
// MCALC | m = acc[WW-1:0] * n' mod 2^WW
// ACC   | acc = (acc + m*N) >> WW, count one digit
// SUB   | final conditional subtract into the result register
// DONE  | o_valid=1, holding o_res until i_ready
module mmm_redc_seq #(
    parameter int IDW = 256,
    parameter int TDW = 522,
    parameter int WW  = 64
) (
    input  logic          clk,
    input  logic          rstn,
    mmm_redc_seq_if.slave bus
);
    localparam int NW = IDW / WW;
    localparam int CW = $clog2(NW + 1);
    localparam int AW = 2 * IDW + 1;

    typedef enum logic [2:0] {
        IDLE,
        MCALC,
        ACC,
        SUB,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [IDW-1:0]  n_r;
    logic [WW-1:0]   np_r;
    logic [WW-1:0]   m_r;
    logic [IDW-1:0]  res_r;
    logic            valid_r;
    logic            ready_r;

    logic [WW-1:0]      m_next;
    logic [IDW+WW-1:0]  mn;
    logic [AW-1:0]      acc_sum;
    logic [AW-1:0]      acc_shr;
    logic [AW-1:0]      n_ext;
    logic               unused_t_hi;

    // Product bits above 2*IDW are don't-care from the multiplier.
    assign unused_t_hi = ^bus.i_t[TDW-1:2*IDW];

    assign m_next  = acc[WW-1:0] * np_r;
    assign mn      = {{WW{1'b0}}, n_r} * {{IDW{1'b0}}, m_r};
    // Low WW bits of acc_sum are zero by choice of m, so the shift drops nothing.
    assign acc_sum = acc + {{(AW-IDW-WW){1'b0}}, mn};
    assign acc_shr = acc_sum >> WW;
    assign n_ext   = {{(AW-IDW){1'b0}}, n_r};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            n_r     <= '0;
            np_r    <= '0;
            m_r     <= '0;
            res_r   <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid && ready_r) begin
                        acc     <= {1'b0, bus.i_t[2*IDW-1:0]};
                        n_r     <= bus.i_n;
                        np_r    <= bus.i_nprime;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        state   <= MCALC;
                    end
                end
                MCALC: begin
                    m_r   <= m_next;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_shr;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NW - 1)) begin
                        state <= SUB;
                    end else begin
                        state <= MCALC;
                    end
                end
                SUB: begin
                    // acc < 2N here, so one subtract lands in [0, N); the
                    // truncated IDW-bit difference equals acc - N.
                    if (acc >= n_ext) begin
                        res_r <= acc[IDW-1:0] - n_r;
                    end else begin
                        res_r <= acc[IDW-1:0];
                    end
                    valid_r <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_r;
    assign bus.o_valid = valid_r;
    assign bus.o_res   = res_r;
endmodule

// File: tb/tb_mmm_redc_seq.sv
// Self-checking bench for mmm_redc_seq against a bit-serial halving model
// of T * 2^-256 mod N.
module tb_mmm_redc_seq;
    localparam int IDW = 256;
    localparam int TDW = 522;
    localparam int WW  = 64;
    localparam int CWD = IDW + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mmm_redc_seq_if #(.IDW(IDW), .TDW(TDW), .WW(WW)) bus ();

    mmm_redc_seq #(.IDW(IDW), .TDW(TDW), .WW(WW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [IDW-1:0] n_mod;
    logic [WW-1:0]  nprime;

    task automatic chk(input string tag, input logic [CWD-1:0] got, input logic [CWD-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // T * 2^-IDW mod N by reducing T mod N then halving mod N IDW times.
    function automatic logic [IDW-1:0] model(input logic [2*IDW-1:0] t);
        logic [2*IDW-1:0] r;
        logic [IDW:0]     x;
        r = t % {{IDW{1'b0}}, n_mod};
        x = {1'b0, r[IDW-1:0]};
        for (int i = 0; i < IDW; i++) begin
            if (x[0]) x = x + {1'b0, n_mod};
            x = x >> 1;
        end
        return x[IDW-1:0];
    endfunction

    function automatic logic [IDW-1:0] rand256();
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < IDW / 32; i++) r = {r[IDW-33:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [IDW-1:0] rand_mod();
        logic [IDW-1:0] r;
        r = rand256();
        return r % n_mod;
    endfunction

    // Enters and leaves at a negedge; returns just after the acceptance edge
    // with the request inputs scrambled.
    task automatic accept(input logic [TDW-1:0] t);
        int n;
        n = 0;
        bus.i_t      = t;
        bus.i_n      = n_mod;
        bus.i_nprime = nprime;
        bus.i_valid  = 1'b1;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) chk("accept_timeout", CWD'(0), CWD'(1));
        @(posedge clk);
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_t      = TDW'({rand256(), rand256(), rand256()});
        bus.i_n      = rand256();
        bus.i_nprime = WW'({$urandom(), $urandom()});
    endtask

    task automatic wait_valid(input bit rnd, output int n);
        n = 0;
        while (!bus.o_valid && n < 200) begin
            if (rnd) bus.i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!bus.o_valid) chk("valid_timeout", CWD'(0), CWD'(1));
    endtask

    task automatic run_op(input logic [TDW-1:0] t, input logic [IDW-1:0] exp,
                          input string tag, input bit rnd);
        int n;
        if (rnd) repeat ($urandom_range(0, 3)) @(negedge clk);
        accept(t);
        wait_valid(rnd, n);
        if (!rnd) chk({tag, "_lat"}, CWD'(n), CWD'(9));
        chk({tag, "_res"}, CWD'(bus.o_res), CWD'(exp));
        chk({tag, "_lt_n"}, CWD'(bus.o_res < n_mod), CWD'(1));
        if (rnd) begin
            bus.i_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld_drop"}, CWD'(bus.o_valid), CWD'(0));
        chk({tag, "_rdy_back"}, CWD'(bus.o_ready), CWD'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TDW-1:0]   t;
        logic [2*IDW-1:0] p;
        logic [IDW-1:0]   a, b, e, e1;
        logic [WW-1:0]    x, n64;
        int               n, extra;

        bus.i_valid  = 1'b0;
        bus.i_t      = '0;
        bus.i_n      = '0;
        bus.i_nprime = '0;
        bus.i_ready  = 1'b1;

        n_mod = {IDW{1'b1}} - IDW'(188);
        n64   = n_mod[WW-1:0];
        x     = n64;
        for (int i = 0; i < 6; i++) x = x * (WW'(2) - n64 * x);
        nprime = -x;

        repeat (3) @(negedge clk);
        chk("rst_ready", CWD'(bus.o_ready), CWD'(1));
        chk("rst_valid", CWD'(bus.o_valid), CWD'(0));
        chk("rst_res", CWD'(bus.o_res), CWD'(0));
        rstn = 1'b1;
        @(negedge clk);

        run_op('0, '0, "zero", 1'b0);
        t = TDW'({IDW'(5), IDW'(0)});
        run_op(t, IDW'(5), "five", 1'b0);
        t = TDW'({n_mod - IDW'(1), IDW'(0)});
        run_op(t, n_mod - IDW'(1), "upper", 1'b0);
        e1 = model(512'(1));
        run_op(TDW'(1), e1, "one", 1'b0);
        t = {10'h3ff, 512'(1)};
        run_op(t, e1, "one_hi", 1'b0);

        // Backpressure, with i_valid held high throughout the operation.
        a = rand_mod();
        b = rand_mod();
        p = {{IDW{1'b0}}, a} * {{IDW{1'b0}}, b};
        e = model(p);
        bus.i_ready = 1'b0;
        accept(TDW'(p));
        bus.i_valid = 1'b1;
        wait_valid(1'b0, n);
        bus.i_valid = 1'b0;
        chk("bp_lat", CWD'(n), CWD'(9));
        chk("bp_res", CWD'(bus.o_res), CWD'(e));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", CWD'(bus.o_valid), CWD'(1));
            chk("bp_hold_res", CWD'(bus.o_res), CWD'(e));
            chk("bp_hold_rdy", CWD'(bus.o_ready), CWD'(0));
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_vld_drop", CWD'(bus.o_valid), CWD'(0));
        chk("bp_rdy_back", CWD'(bus.o_ready), CWD'(1));
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_valid) extra++;
        end
        chk("bp_single_result", CWD'(extra), CWD'(0));

        // Reset during the third ACC cycle.
        a = rand_mod();
        b = rand_mod();
        p = {{IDW{1'b0}}, a} * {{IDW{1'b0}}, b};
        e = model(p);
        accept(TDW'(p));
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", CWD'(bus.o_valid), CWD'(0));
        chk("mid_rst_res", CWD'(bus.o_res), CWD'(0));
        chk("mid_rst_ready", CWD'(bus.o_ready), CWD'(1));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_op(TDW'(p), e, "post_rst", 1'b0);

        for (int k = 0; k < 1000; k++) begin
            a = rand_mod();
            b = rand_mod();
            p = {{IDW{1'b0}}, a} * {{IDW{1'b0}}, b};
            e = model(p);
            t = {10'($urandom()), p};
            run_op(t, e, "rnd", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
